// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch/decode boundary: the fetch queue entry layout and
// the default queue depth used at top-level instantiation.
package fetch_queue_pkg;

  localparam int FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [63:0] order;
  } fetch_queue_t;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode with flush-on-redirect.
// Optional FETCH_QUEUE_BYPASS_EN: zero-latency enq->deq forwarding when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enq,
  input  logic [159:0]   enq_data,
  output logic           full_fq,
  output logic           deq_valid,
  output logic [159:0]   deq_data,
  input  logic           deq_ready,
  input  logic           flush,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  fetch_queue_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_q;
  logic             stored_valid;
  logic             push;
  logic             pop;

  assign count        = count_q;
  assign full_fq      = (count_q == FULL_CNT);
  assign stored_valid = (count_q != '0);
  assign pop          = stored_valid && deq_ready && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming entry; if decode takes it now it never lands in storage.
  assign bypass    = !stored_valid && enq && !flush;
  assign deq_valid = stored_valid || bypass;
  assign deq_data  = bypass ? enq_data : mem[head];
  assign push      = enq && !full_fq && !flush && !(bypass && deq_ready);
`else
  assign deq_valid = stored_valid;
  assign deq_data  = mem[head];
  assign push      = enq && !full_fq && !flush;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Redirect: drop everything; stale storage is unreachable once pointers reset.
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[tail] <= fetch_queue_t'(enq_data);
        tail      <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (PTR_W + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (PTR_W + 1)'(1);
      end
    end
  end

  // Fetch is expected to gate enq with full_fq; an ignored entry is a fetch-side bug.
  always @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(enq && full_fq))
        else $warning("fetch_queue: enq while full_fq, entry dropped");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected entries,
// a negedge monitor pops and compares on every accepted dequeue.
module tb_fetch_queue;

  logic         clk;
  logic         rst_n;
  logic         enq;
  logic [159:0] enq_data;
  logic         full_fq;
  logic         deq_valid;
  logic [159:0] deq_data;
  logic         deq_ready;
  logic         flush;
  logic [3:0]   count;

  int checks;
  int fails;
  logic [159:0] sb [$];

  fetch_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq       (enq),
    .enq_data  (enq_data),
    .full_fq   (full_fq),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [159:0] mk(input logic [63:0] ord, input logic [31:0] pc);
    return {32'h00000013 ^ ord[31:0], pc, pc + 32'd4, ord};
  endfunction

  function automatic logic [159:0] mko(input logic [63:0] ord);
    return mk(ord, 32'h60000000 + (ord[31:0] << 2));
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [159:0] d, input bit accepted);
    enq      = 1'b1;
    enq_data = d;
    if (accepted) sb.push_back(d);
  endtask

  // Monitor: a dequeue happens at the next edge whenever the handshake holds without flush.
  always @(negedge clk) begin
    if (rst_n && deq_valid && deq_ready && !flush) begin
      if (sb.size() == 0) begin
        chk("deq_unexpected", deq_data, '0);
      end else begin
        chk("deq_data", deq_data, sb.pop_front());
      end
    end
  end

  initial begin
    checks    = 0;
    fails     = 0;
    rst_n     = 1'b0;
    enq       = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    #3;
    chk("rst_count", 160'(count), 160'd0);
    chk("rst_deq_valid", 160'(deq_valid), 160'd0);
    chk("rst_full", 160'(full_fq), 160'd0);
    chk("rst_deq_data", deq_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fill to DEPTH with decode stalled, then one extra enq that must be ignored.
    for (int i = 0; i < 8; i++) begin
      drive_enq(mko(64'(i)), 1'b1);
      step();
    end
    chk("fill_full", 160'(full_fq), 160'd1);
    chk("fill_count", 160'(count), 160'd8);
    drive_enq(mko(64'd99), 1'b0);
    step();
    enq = 1'b0;
    chk("drop_count", 160'(count), 160'd8);
    chk("drop_head", deq_data, mko(64'd0));

    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    deq_ready = 1'b0;
    chk("drain_valid", 160'(deq_valid), 160'd0);
    chk("drain_count", 160'(count), 160'd0);
    chk("drain_full", 160'(full_fq), 160'd0);

    // Steady state at occupancy 3 with pointers wrapping.
    for (int i = 8; i < 11; i++) begin
      drive_enq(mko(64'(i)), 1'b1);
      step();
    end
    chk("sim_pre_count", 160'(count), 160'd3);
    deq_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      drive_enq(mko(64'(11 + j)), 1'b1);
      step();
      chk("sim_count", 160'(count), 160'd3);
    end
    enq = 1'b0;
    for (int i = 0; i < 3; i++) step();
    deq_ready = 1'b0;
    chk("sim_post_valid", 160'(deq_valid), 160'd0);

    // Flush with simultaneous enq and deq handshake: nothing enters, nothing leaves.
    for (int i = 31; i < 35; i++) begin
      drive_enq(mko(64'(i)), 1'b1);
      step();
    end
    chk("flush_pre_count", 160'(count), 160'd4);
    flush     = 1'b1;
    deq_ready = 1'b1;
    sb.delete();
    drive_enq(mko(64'd35), 1'b0);
    step();
    flush     = 1'b0;
    deq_ready = 1'b0;
    chk("flush_count", 160'(count), 160'd0);
    chk("flush_valid", 160'(deq_valid), 160'd0);
    drive_enq(mk(64'd42, 32'h60000100), 1'b1);
    step();
    enq = 1'b0;
    chk("redirect_valid", 160'(deq_valid), 160'd1);
    chk("redirect_pc", 160'(deq_data[127:96]), 160'h60000100);
    chk("redirect_order", 160'(deq_data[63:0]), 160'd42);
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("redirect_count", 160'(count), 160'd0);

    // Enq into an empty queue with decode ready.
    deq_ready = 1'b1;
    drive_enq(mko(64'd7), 1'b1);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("byp_valid", 160'(deq_valid), 160'd1);
    chk("byp_order", 160'(deq_data[63:0]), 160'd7);
    step();
    enq = 1'b0;
    #1;
    chk("byp_count", 160'(count), 160'd0);
    chk("byp_after_valid", 160'(deq_valid), 160'd0);
`else
    chk("nobyp_valid", 160'(deq_valid), 160'd0);
    step();
    enq = 1'b0;
    #1;
    chk("nobyp_next_valid", 160'(deq_valid), 160'd1);
    chk("nobyp_count", 160'(count), 160'd1);
    step();
    chk("nobyp_after_count", 160'(count), 160'd0);
`endif
    deq_ready = 1'b0;

    // Asynchronous reset in the middle of a cycle with entries held.
    for (int i = 100; i < 105; i++) begin
      drive_enq(mko(64'(i)), 1'b1);
      step();
    end
    enq = 1'b0;
    chk("mid_pre_count", 160'(count), 160'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 160'(count), 160'd0);
    chk("mid_rst_valid", 160'(deq_valid), 160'd0);
    chk("mid_rst_full", 160'(full_fq), 160'd0);
    chk("mid_rst_data", deq_data, '0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 160'(deq_valid), 160'd0);

    chk("sb_empty", 160'(sb.size()), 160'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
